// File: rtl/eight_left_shift_pkg.sv
// Shared processor datapath constants for the immediate-upper shifter.
package eight_left_shift_pkg;

    localparam int WORD_W = 16;
    localparam int IMM8_W = 8;
    localparam logic [IMM8_W-1:0] ZERO_BYTE = 8'h00;

endpackage

// File: rtl/eight_left_shift_imm_shift_comb.sv
// Purely combinational immediate-upper shift: {in, zeros}.
module imm_shift_comb
    import eight_left_shift_pkg::*;
#(
    parameter int IN_W  = IMM8_W,
    parameter int OUT_W = WORD_W
) (
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out
);

    // Low bits are literal zeros so X on in can never reach them.
    assign out = {in, {(OUT_W - IN_W){1'b0}}};

endmodule

// File: rtl/eight_left_shift.sv
// Immediate-upper shifter: combinational result plus a registered copy.
module eight_left_shift
    import eight_left_shift_pkg::*;
#(
    parameter int IN_W  = IMM8_W,
    parameter int SHIFT = 8,
    parameter int OUT_W = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in,
    input  logic             in_valid,
    input  logic             hold,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_q,
    output logic             out_q_valid
);

    if (SHIFT + IN_W != OUT_W) begin : g_width_check
        $error("eight_left_shift: SHIFT + IN_W must equal OUT_W");
    end

    imm_shift_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_shift (
        .in  (in),
        .out (out)
    );

    // Priority: reset, then hold (stall), then capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_q_valid <= 1'b0;
        end else if (hold) begin
            out_q       <= out_q;
            out_q_valid <= out_q_valid;
        end else if (in_valid) begin
            out_q       <= out;
            out_q_valid <= 1'b1;
        end else begin
            out_q_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eight_left_shift.sv
// Directed self-checking bench for eight_left_shift.
module tb_eight_left_shift;

    logic        clk;
    logic        clk_en;
    logic        reset;
    logic [7:0]  in;
    logic        in_valid;
    logic        hold;
    logic [15:0] out;
    logic [15:0] out_q;
    logic        out_q_valid;

    int passed;
    int total;

    eight_left_shift dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .in_valid    (in_valid),
        .hold        (hold),
        .out         (out),
        .out_q       (out_q),
        .out_q_valid (out_q_valid)
    );

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        clk_en   = 1'b0;
        reset    = 1'b1;
        hold     = 1'b0;
        in_valid = 1'b0;

        in = 8'h37;
        #10;
        check("comb_37", out, 16'h3700);
        in = 8'h15;
        #1;
        check("comb_15", out, 16'h1500);
        in = 8'hFF;
        #1;
        check("comb_ff", out, 16'hFF00);
        in = 8'h00;
        #1;
        check("comb_00", out, 16'h0000);

        clk_en = 1'b1;
        step();
        step();
        check("rst_q", out_q, 16'h0000);
        check("rst_v", {15'd0, out_q_valid}, 16'd0);

        reset    = 1'b0;
        in       = 8'hA5;
        in_valid = 1'b1;
        step();
        check("cap_q", out_q, 16'hA500);
        check("cap_v", {15'd0, out_q_valid}, 16'd1);
        in_valid = 1'b0;
        step();
        check("idle_q", out_q, 16'hA500);
        check("idle_v", {15'd0, out_q_valid}, 16'd0);

        hold     = 1'b1;
        in       = 8'h99;
        in_valid = 1'b1;
        step();
        check("hold_inv_q", out_q, 16'hA500);
        check("hold_inv_v", {15'd0, out_q_valid}, 16'd0);

        hold = 1'b0;
        in   = 8'h12;
        step();
        check("cap12_q", out_q, 16'h1200);
        check("cap12_v", {15'd0, out_q_valid}, 16'd1);

        hold = 1'b1;
        in   = 8'h34;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold%0d_q", i), out_q, 16'h1200);
            check($sformatf("hold%0d_v", i), {15'd0, out_q_valid}, 16'd1);
        end
        check("hold_comb", out, 16'h3400);

        hold = 1'b0;
        step();
        check("rel_q", out_q, 16'h3400);
        check("rel_v", {15'd0, out_q_valid}, 16'd1);

        reset    = 1'b1;
        hold     = 1'b1;
        in       = 8'h77;
        in_valid = 1'b1;
        step();
        check("rprio_q", out_q, 16'h0000);
        check("rprio_v", {15'd0, out_q_valid}, 16'd0);
        check("rprio_comb", out, 16'h7700);

        reset    = 1'b0;
        hold     = 1'b0;
        in_valid = 1'b0;
        step();
        check("post_rst_v", {15'd0, out_q_valid}, 16'd0);
        clk_en = 1'b0;

        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b  = 8'(i);
            in = b;
            #1;
            check($sformatf("sweep_%02h", b), out, {b, 8'h00});
            check($sformatf("low_%02h", b), {8'h00, out[7:0]}, 16'h0000);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/eight_left_shift.md
Name: eight_left_shift

Overview:
- Immediate-upper shifter for the 16-bit processor datapath.
- Places an 8-bit immediate in the upper byte of a 16-bit word and zero-fills the lower byte (out = in << 8). Used for load-upper-immediate style operations.
- The shifted word is available combinationally, for same-cycle datapath use.
- A registered copy with valid/enable is also provided, for pipelined use.

Parameters:
- IN_W, 8, immediate width.
- SHIFT, 8, left-shift amount in bits; must equal OUT_W - IN_W.
- OUT_W, 16, datapath word width.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous active-high reset.
- in, input, IN_W, immediate byte to shift.
- in_valid, input, 1, qualifies in for capture into the registered path.
- hold, input, 1, freezes the registered path (stall).
- out, output, OUT_W, combinational result {in, 8'h00}.
- out_q, output, OUT_W, registered result.
- out_q_valid, output, 1, out_q holds a captured result.

Behaviour:
- Combinational path:
  - out[15:8] = in[7:0]; out[7:0] = 8'h00.
  - Pure combinational; no dependence on clk or reset; zero-cycle latency.
  - Valid whenever in is stable.
- No X propagation into the low byte: out[7:0] is constant 0 even if in is X.
- Registered path, evaluated on the rising edge of clk, in priority order:
  - reset=1: out_q <= 16'h0000, out_q_valid <= 0. Reset dominates hold and in_valid.
  - else hold=1: out_q and out_q_valid keep their values. in_valid is ignored.
  - else in_valid=1: out_q <= {in, 8'h00}, out_q_valid <= 1.
  - else: out_q keeps its value, out_q_valid <= 0.
- Latency of the registered path is 1 cycle from in_valid to out_q_valid.
- Reset mid-stream: any pending capture is discarded. out_q_valid is low in the cycle after reset.
- Width rules:
  - No truncation; bits of in shifted beyond OUT_W cannot occur with the defaults.
  - Elaboration check: fail if SHIFT + IN_W != OUT_W.
- Boundary values:
  - in = 8'h00 gives out = 16'h0000.
  - in = 8'hFF gives out = 16'hFF00.
  - out[7:0] is never nonzero.

Decomposition:
- Shared processor package holds: WORD_W = 16, IMM8_W = 8, and the zero-byte constant 8'h00.
- Sub-module: imm_shift_comb, the purely combinational shift. It is instantiated once and feeds both out and the out_q register.
- The top level holds only the register, the valid flag and the priority logic.

Test Plan:
- Combinational: in = 8'h37, wait 10 ns with no clock edge -> out = 16'h3700.
- Combinational: in = 8'h15 -> out = 16'h1500. in = 8'hFF -> out = 16'hFF00. in = 8'h00 -> out = 16'h0000.
- Registered capture: reset for 2 cycles, then in = 8'hA5, in_valid = 1 for one edge -> next cycle out_q = 16'hA500 and out_q_valid = 1; the following cycle (in_valid = 0) out_q_valid = 0 and out_q stays 16'hA500.
- Hold: capture 8'h12, then hold = 1 with in = 8'h34, in_valid = 1 for 3 cycles -> out_q stays 16'h1200 and out_q_valid stays 1; after hold drops with in_valid = 1 -> out_q = 16'h3400.
- Reset priority: reset = 1 together with hold = 1 and in_valid = 1, in = 8'h77 -> next cycle out_q = 16'h0000 and out_q_valid = 0.
- Exhaustive: sweep in over 0..255 -> out == {in, 8'h00} and out[7:0] == 0 every time.
